// File: rtl/debounce_pkg.sv
// Shared types and constants for the push-button debouncer.
// Holds the FSM state encoding, default 100 MHz timings and counter sizing.
package debounce_pkg;

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    CHK_HIGH = 2'd1,
    HIGH     = 2'd2,
    CHK_LOW  = 2'd3
  } state_t;

  // 1 ms and 1 s at 100 MHz
  localparam int DEF_STABLE_CYCLES = 100_000;
  localparam int DEF_LONG_CYCLES   = 100_000_000;

  // Counter width that holds 0..n-1, never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_edge_detector_window.sv
// stable_window_counter: saturating up-counter that flags terminal count.
// Ports: clk, rst_n, clear, enable in; done out (count == N-1).
module stable_window_counter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt;

  assign done = (cnt == LAST);

  // Holds at LAST so the count never passes its compare value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !done) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/debounce_edge_detector.sv
// Debouncer with edge, long-press and press-count outputs.
// Ports: clk, rst_n, sync_in in; level, rise, fall, long_press, press_count out.
module debounce_edge_detector
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync_in,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic             long_press,
  output logic [CNT_W-1:0] press_count
);

  localparam int STB_W = cnt_w(STABLE_CYCLES);
  localparam int LNG_W = cnt_w(LONG_CYCLES);

  state_t state, next;

  logic stb_clr, stb_en, stb_done;
  logic lng_clr, lng_en, lng_done;
  logic do_rise, do_fall, do_long;
  logic long_done;

  stable_window_counter #(
    .N (STABLE_CYCLES),
    .W (STB_W)
  ) u_stb (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (stb_clr),
    .enable (stb_en),
    .done   (stb_done)
  );

  stable_window_counter #(
    .N (LONG_CYCLES),
    .W (LNG_W)
  ) u_lng (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (lng_clr),
    .enable (lng_en),
    .done   (lng_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOW;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next    = state;
    stb_clr = 1'b0;
    stb_en  = 1'b0;
    lng_clr = 1'b0;
    lng_en  = 1'b0;
    do_rise = 1'b0;
    do_fall = 1'b0;
    do_long = 1'b0;
    unique case (state)
      LOW: begin
        stb_clr = 1'b1;
        if (sync_in) next = CHK_HIGH;
      end
      CHK_HIGH: begin
        if (!sync_in) begin
          next    = LOW;
          stb_clr = 1'b1;
        end else if (stb_done) begin
          next    = HIGH;
          stb_clr = 1'b1;
          lng_clr = 1'b1;
          do_rise = 1'b1;
        end else begin
          stb_en = 1'b1;
        end
      end
      HIGH: begin
        stb_clr = 1'b1;
        if (!sync_in) begin
          next = CHK_LOW;
        end else if (!long_done) begin
          // Terminal count fires once; the counter then holds
          if (lng_done) do_long = 1'b1;
          else          lng_en  = 1'b1;
        end
      end
      CHK_LOW: begin
        // Long-press counter is frozen while a release is pending
        if (sync_in) begin
          next    = HIGH;
          stb_clr = 1'b1;
        end else if (stb_done) begin
          next    = LOW;
          stb_clr = 1'b1;
          do_fall = 1'b1;
        end else begin
          stb_en = 1'b1;
        end
      end
      default: begin
        next    = LOW;
        stb_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level       <= 1'b0;
      rise        <= 1'b0;
      fall        <= 1'b0;
      long_press  <= 1'b0;
      long_done   <= 1'b0;
      press_count <= '0;
    end else begin
      rise       <= do_rise;
      fall       <= do_fall;
      long_press <= do_long;
      if (do_rise) begin
        level       <= 1'b1;
        long_done   <= 1'b0;
        press_count <= press_count + CNT_W'(1);
      end else if (do_fall) begin
        level <= 1'b0;
      end
      if (do_long) long_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_debounce_edge_detector.sv
// Self-checking bench for debounce_edge_detector (4/10/2 config).
// Directed plan items plus random bouncy stimulus against a run-length model.
module tb_debounce_edge_detector;

  localparam int SC = 4;
  localparam int LC = 10;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sync_in;
  logic          level, rise, fall, long_press;
  logic [CW-1:0] press_count;

  int errors = 0;
  int checks = 0;

  bit            m_lv, m_ld, m_rise, m_fall, m_long;
  int            m_run, m_hold;
  logic [CW-1:0] m_cnt;

  int n_rise, n_fall, n_long;

  debounce_edge_detector #(
    .STABLE_CYCLES (SC),
    .LONG_CYCLES   (LC),
    .CNT_W         (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sync_in     (sync_in),
    .level       (level),
    .rise        (rise),
    .fall        (fall),
    .long_press  (long_press),
    .press_count (press_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lv = 0; m_ld = 0; m_rise = 0; m_fall = 0; m_long = 0;
    m_run = 0; m_hold = 0; m_cnt = '0;
  endtask

  // Level flips on the (SC+1)th consecutive differing sample.
  // Long press counts edges spent high with no release pending.
  task automatic model_step(input bit s);
    m_rise = 0; m_fall = 0; m_long = 0;
    if (m_lv && m_run == 0 && s && !m_ld) begin
      m_hold++;
      if (m_hold == LC) begin
        m_long = 1;
        m_ld = 1;
      end
    end
    if (s != m_lv) m_run++;
    else m_run = 0;
    if (m_run == SC + 1) begin
      m_lv = s;
      m_run = 0;
      if (s) begin
        m_rise = 1;
        m_cnt = m_cnt + 1'b1;
        m_hold = 0;
        m_ld = 0;
      end else begin
        m_fall = 1;
      end
    end
  endtask

  task automatic check_all();
    check("level", level, m_lv);
    check("rise", rise, m_rise);
    check("fall", fall, m_fall);
    check("long_press", long_press, m_long);
    check("press_count", press_count, m_cnt);
    if (rise && fall) check("rise_and_fall", 1, 0);
  endtask

  task automatic step(input bit s);
    sync_in = s;
    @(posedge clk);
    model_step(s);
    #1;
    check_all();
    n_rise += int'(rise);
    n_fall += int'(fall);
    n_long += int'(long_press);
  endtask

  // Returns 1-based edge index of the first observed rise, 0 if none
  task automatic find_rise(input int max_edges, output int at);
    at = 0;
    for (int e = 1; e <= max_edges; e++) begin
      step(1'b1);
      if (rise && at == 0) at = e;
    end
  endtask

  task automatic find_fall(input int max_edges, output int at);
    at = 0;
    for (int e = 1; e <= max_edges; e++) begin
      step(1'b0);
      if (fall && at == 0) at = e;
    end
  endtask

  initial begin
    int at, len;
    bit v;
    n_rise = 0; n_fall = 0; n_long = 0;

    // 1: reset with input held high
    rst_n = 1'b0;
    sync_in = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_all();
    @(negedge clk) rst_n = 1'b1;
    find_rise(8, at);
    check("reset_rise_edge", at, 5);
    check("first_count", press_count, 1);

    // 2: bounce then steady high; 3: long hold then release
    repeat (8) step(1'b0);
    n_long = 0;
    step(1'b1); step(1'b1); step(1'b0);
    find_rise(8, at);
    check("bounce_rise_edge", at, 5);
    repeat (20) step(1'b1);
    check("long_once", n_long, 1);
    find_fall(8, at);
    check("long_fall_edge", at, 5);
    check("level_low", level, 0);

    // 4: short press, no long press
    n_long = 0;
    find_rise(5, at);
    repeat (6) step(1'b1);
    find_fall(8, at);
    check("short_fall_edge", at, 5);
    check("short_no_long", n_long, 0);

    // 5: four clean presses, wrap of press_count
    n_rise = 0; n_fall = 0;
    for (int p = 0; p < 4; p++) begin
      repeat (8) step(1'b1);
      repeat (8) step(1'b0);
    end
    check("four_rises", n_rise, 4);
    check("four_falls", n_fall, 4);

    // 6: async reset while a release is pending
    repeat (8) step(1'b1);
    step(1'b0); step(1'b0);
    #2 rst_n = 1'b0;
    sync_in = 1'b1;
    #1;
    check("async_level", level, 0);
    check("async_fall", fall, 0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    find_rise(8, at);
    check("rerun_rise_edge", at, 5);

    // Random bouncy segments, mostly short, some long holds
    v = 1'b0;
    for (int k = 0; k < 400; k++) begin
      v = ~v;
      if ($urandom_range(0, 7) == 0) len = $urandom_range(10, 25);
      else len = $urandom_range(1, 8);
      repeat (len) step(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
